// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronizes and debounces four push-buttons; emits clean levels,
// one-cycle press/release pulses and sticky press flags.
module btn_conditioner #(
    parameter int unsigned DB_CYCLES  = 1000,
    parameter int unsigned CNT_W      = 10,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [3:0] btn_raw_i,
    input  logic [3:0] clr_i,
    output logic [3:0] btn_o,
    output logic [3:0] press_o,
    output logic [3:0] release_o,
    output logic [3:0] held_o
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);
    logic [3:0] s1_q, s2_q, btn_q, btn_d, prev_q, press_q, press_d, rel_q, rel_d, held_q, held_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            btn_d[i] = btn_q[i];
            if (s2_q[i] != btn_q[i]) begin
                if (cnt_q[i] == LAST) btn_d[i] = s2_q[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end
    assign press_d = btn_q & ~prev_q;
    assign rel_d   = ~btn_q & prev_q;
    // press_q term keeps a clear that lands in the pulse cycle from beating the set
    assign held_d  = press_d | press_q | (held_q & ~clr_i);
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            s1_q    <= '0;
            s2_q    <= '0;
            btn_q   <= '0;
            prev_q  <= '0;
            press_q <= '0;
            rel_q   <= '0;
            held_q  <= '0;
            cnt_q   <= '{default: '0};
        end else begin
            s1_q    <= btn_raw_i ^ {4{ACTIVE_LOW}};
            s2_q    <= s1_q;
            btn_q   <= btn_d;
            prev_q  <= btn_q;
            press_q <= press_d;
            rel_q   <= rel_d;
            held_q  <= held_d;
            cnt_q   <= cnt_d;
        end
    end
    assign btn_o     = btn_q;
    assign press_o   = press_q;
    assign release_o = rel_q;
    assign held_o    = held_q;
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed checks of debounce latency, pulses, sticky flags and reset.
module tb_btn_conditioner;
    logic       clk = 1'b0;
    logic       reset_ni;
    logic [3:0] btn_raw, clr, btn, press, rel, held;
    int         n_chk = 0;
    int         n_fail = 0;
    always #5 clk = ~clk;
    btn_conditioner #(.DB_CYCLES(4), .CNT_W(10), .ACTIVE_LOW(1'b1)) dut (
        .clk_i(clk), .reset_ni(reset_ni), .btn_raw_i(btn_raw), .clr_i(clr),
        .btn_o(btn), .press_o(press), .release_o(rel), .held_o(held)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    initial begin
        int first, presses;
        logic [3:0] acc;
        reset_ni = 1'b0;
        btn_raw  = 4'hF;
        clr      = 4'h0;
        #12;
        check("rst_btn", btn, 0);
        check("rst_press", press, 0);
        check("rst_release", rel, 0);
        check("rst_held", held, 0);
        @(negedge clk) reset_ni = 1'b1;
        tick(3);
        // all pressed, then async reset mid-cycle
        btn_raw = 4'h0;
        tick(8);
        check("all_btn", btn, 4'hF);
        check("all_held", held, 4'hF);
        #3 reset_ni = 1'b0;
        #1;
        check("async_btn", btn, 0);
        check("async_held", held, 0);
        check("async_press", press, 0);
        repeat (2) @(negedge clk);
        reset_ni = 1'b1;
        tick(5);
        check("rel_edge4_btn", btn, 0);
        tick(1);
        check("rel_edge5_btn", btn, 4'hF);
        check("rel_edge5_press", press, 0);
        tick(1);
        check("rel_press", press, 4'hF);
        check("rel_held", held, 4'hF);
        tick(1);
        check("rel_press_end", press, 0);
        clr = 4'hF;
        tick(1);
        check("clr_all", held, 0);
        clr = 4'h0;
        btn_raw = 4'hF;
        tick(6);
        check("unpress_btn", btn, 0);
        tick(1);
        check("unpress_release", rel, 4'hF);
        check("unpress_nopress", press, 0);
        tick(1);
        check("unpress_release_end", rel, 0);
        // clean press on bit 2
        btn_raw = 4'b1011;
        tick(5);
        check("b2_edge4", btn, 0);
        tick(1);
        check("b2_edge5", btn, 4'b0100);
        tick(1);
        check("b2_press", press, 4'b0100);
        check("b2_held", held, 4'b0100);
        tick(1);
        check("b2_press_end", press, 0);
        btn_raw = 4'hF;
        tick(6);
        check("b2_btn_off", btn, 0);
        tick(1);
        check("b2_release", rel, 4'b0100);
        tick(1);
        check("b2_release_end", rel, 0);
        clr = 4'b0100;
        tick(1);
        check("b2_clr", held, 0);
        clr = 4'h0;
        // bounce on bit 0: low 3, high 1, then low
        first = 0;
        presses = 0;
        for (int k = 1; k <= 15; k++) begin
            btn_raw = (k <= 3 || k >= 5) ? 4'b1110 : 4'b1111;
            tick(1);
            if (press[0]) presses++;
            if (btn[0] && first == 0) first = k;
        end
        check("bounce_commit_tick", first, 10);
        check("bounce_presses", presses, 1);
        btn_raw = 4'hF;
        tick(8);
        clr = 4'hF;
        tick(1);
        clr = 4'h0;
        check("bounce_idle", btn, 0);
        // glitch of 3 cycles on bit 1
        acc = 0;
        for (int k = 1; k <= 12; k++) begin
            btn_raw = (k <= 3) ? 4'b1101 : 4'b1111;
            tick(1);
            acc = acc | btn | press | held;
        end
        check("glitch_reject", acc, 0);
        // sticky flag and clear priority on bit 3
        btn_raw = 4'b0111;
        tick(7);
        check("b3_press", press, 4'b1000);
        tick(1);
        check("b3_held", held, 4'b1000);
        clr = 4'b1000;
        tick(1);
        check("b3_clr", held, 0);
        clr = 4'h0;
        btn_raw = 4'hF;
        tick(8);
        btn_raw = 4'b0111;
        tick(6);
        check("b3_btn_again", btn, 4'b1000);
        clr = 4'b1000;
        tick(1);
        check("b3_press_again", press, 4'b1000);
        check("b3_set_priority", held, 4'b1000);
        tick(1);
        check("b3_held_after", held, 4'b1000);
        clr = 4'h0;
        tick(1);
        check("b3_held_keep", held, 4'b1000);
        clr = 4'b1000;
        tick(1);
        check("b3_clr_again", held, 0);
        clr = 4'h0;
        btn_raw = 4'hF;
        tick(8);
        // reset during settling discards the partial count
        btn_raw = 4'b1110;
        tick(2);
        #3 reset_ni = 1'b0;
        repeat (2) @(negedge clk);
        reset_ni = 1'b1;
        tick(5);
        check("settle_rst_early", btn, 0);
        tick(1);
        check("settle_rst_commit", btn, 4'b0001);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
